// File: rtl/axis_rate_sched.sv
// Frame-granular AXI4-Stream scheduler. Grants one input port at a time, in
// round-robin order, to a shared egress stream. Each port has a token-bucket
// credit that is spent by accepted beats and topped up on a common refill
// tick. Credit only gates the start of a frame. Once a frame starts it always
// runs to completion, so the credit can go negative (deficit).

// Per-port credit counter. Signed CREDIT_WIDTH+1 bits. The ceiling is applied
// only on refill cycles, and the floor saturates at -2^CREDIT_WIDTH.
module axis_rate_sched_credit #(
  parameter int CREDIT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    refill,
  input  logic                    dec,
  input  logic [CREDIT_WIDTH-1:0] inc,
  input  logic [CREDIT_WIDTH-1:0] cmax,
  output logic [CREDIT_WIDTH:0]   credit
);
  // Headroom: credit + inc can reach about 2^(CW+1), so 3 extra bits are enough.
  localparam int EW = CREDIT_WIDTH + 3;
  localparam logic signed [EW-1:0] CREDIT_MIN = {3'b111, {CREDIT_WIDTH{1'b0}}};

  logic signed [EW-1:0] cur, inc_x, dec_x, hi_x, sum, nxt;

  assign cur   = EW'($signed(credit));
  assign inc_x = refill ? EW'({1'b0, inc}) : '0;
  assign dec_x = EW'(dec);
  assign hi_x  = EW'({1'b0, cmax});
  assign sum   = cur + inc_x - dec_x;

  // Clamp: the ceiling applies only when refilling; the floor saturates.
  always_comb begin
    nxt = sum;
    if (refill && sum > hi_x) nxt = hi_x;
    else if (sum < CREDIT_MIN) nxt = CREDIT_MIN;
  end

  // Credit register
  always_ff @(posedge clk) begin
    if (rst) credit <= '0;
    else     credit <= (CREDIT_WIDTH+1)'(nxt);
  end
endmodule

module axis_rate_sched #(
  parameter int PORTS        = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int USER_WIDTH   = 1,
  parameter int CREDIT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  output logic [PORTS-1:0]              s_axis_tready,
  input  logic [PORTS-1:0]              s_axis_tlast,
  input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  input  logic                          sched_enable,
  input  logic [15:0]                   refill_period,
  input  logic [PORTS*CREDIT_WIDTH-1:0] credit_inc,
  input  logic [PORTS*CREDIT_WIDTH-1:0] credit_max,
  output logic                          busy,
  output logic [$clog2(PORTS)-1:0]      grant
);
  localparam int GW = $clog2(PORTS);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                           state, state_nxt;
  logic [GW-1:0]                    grant_nxt;
  logic                             found;
  logic [15:0]                      refill_cnt;
  logic                             refill;
  logic                             accept;
  logic [PORTS-1:0]                 eligible;
  logic [PORTS-1:0]                 dec;
  logic [PORTS-1:0][CREDIT_WIDTH:0] credit;

  // Shared refill tick. Using >= means that lowering refill_period below the
  // current count refills at once.
  assign refill = (refill_cnt >= refill_period);

  // Refill counter: reloads to 0 on every refill cycle.
  always_ff @(posedge clk) begin
    if (rst)         refill_cnt <= '0;
    else if (refill) refill_cnt <= '0;
    else             refill_cnt <= refill_cnt + 16'd1;
  end

  assign accept = (state == ACTIVE) && s_axis_tvalid[grant] && m_axis_tready;
  assign dec    = accept ? (PORTS'(1) << grant) : '0;

  // Per-port credit lanes. A port is eligible when it has a valid beat and
  // strictly positive registered credit.
  for (genvar i = 0; i < PORTS; i++) begin : g_lane
    axis_rate_sched_credit #(.CREDIT_WIDTH(CREDIT_WIDTH)) u_credit (
      .clk    (clk),
      .rst    (rst),
      .refill (refill),
      .dec    (dec[i]),
      .inc    (credit_inc[i*CREDIT_WIDTH +: CREDIT_WIDTH]),
      .cmax   (credit_max[i*CREDIT_WIDTH +: CREDIT_WIDTH]),
      .credit (credit[i])
    );
    assign eligible[i] = s_axis_tvalid[i] && !credit[i][CREDIT_WIDTH] &&
                         (|credit[i][CREDIT_WIDTH-1:0]);
  end

  // State and grant registers. After reset, grant = PORTS-1 so that port 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= GW'(PORTS-1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  // Next state: round-robin search from grant+1 in IDLE; leave ACTIVE on the
  // accepted last beat.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    found     = 1'b0;
    case (state)
      IDLE: begin
        if (sched_enable) begin
          for (int k = 1; k <= PORTS; k++) begin
            if (!found && eligible[GW'((int'(grant) + k) % PORTS)]) begin
              found     = 1'b1;
              grant_nxt = GW'((int'(grant) + k) % PORTS);
            end
          end
        end
        if (found) state_nxt = ACTIVE;
      end
      ACTIVE: if (accept && s_axis_tlast[grant]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: zero-latency pass-through of the granted port while ACTIVE.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    busy          = (state == ACTIVE);
    if (state == ACTIVE) begin
      m_axis_tvalid        = s_axis_tvalid[grant];
      s_axis_tready[grant] = m_axis_tready;
    end
  end

  assign m_axis_tdata = s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign m_axis_tuser = s_axis_tuser[int'(grant)*USER_WIDTH +: USER_WIDTH];
  assign m_axis_tlast = s_axis_tlast[grant];
endmodule
